// File: rtl/pipe_pkg.sv
// Shared pipeline types: field widths, EX control bundle and its bubble value.
package pipe_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned IMM_W      = 16;
  localparam int unsigned ALU_OP_W   = 4;
  localparam int unsigned PERF_CNT_W = 16;

  // Execute-stage control strobes carried through ID/EX.
  typedef struct packed {
    logic                alu_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_reg_if.sv
// ID/EX bus: decode-side fields, external stall/flush, registered EX fields, id_hold.
// master: decode/control side driving id_* and stall/flush.
// slave : the ID/EX register producing ex_* and id_hold.
interface id_ex_reg_if
  import pipe_pkg::*;
#(
  parameter int unsigned data_width = 32
);
  logic                  stall;
  logic                  flush;
  logic                  id_valid;
  logic [data_width-1:0] id_rs_data;
  logic [data_width-1:0] id_rt_data;
  logic [IMM_W-1:0]      id_imm;
  logic [REG_ADDR_W-1:0] id_rs_addr;
  logic [REG_ADDR_W-1:0] id_rt_addr;
  logic [REG_ADDR_W-1:0] id_rd_addr;
  logic                  id_uses_rt;
  logic                  id_alu_src;
  logic [ALU_OP_W-1:0]   id_alu_op;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_mem_write;
  logic                  id_mem_to_reg;

  logic                  ex_valid;
  logic [data_width-1:0] ex_rs_data;
  logic [data_width-1:0] ex_rt_data;
  logic [IMM_W-1:0]      ex_imm;
  logic [REG_ADDR_W-1:0] ex_rs_addr;
  logic [REG_ADDR_W-1:0] ex_rt_addr;
  logic [REG_ADDR_W-1:0] ex_rd_addr;
  logic                  ex_alu_src;
  logic [ALU_OP_W-1:0]   ex_alu_op;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic                  ex_mem_to_reg;
  logic                  id_hold;

  modport master (
    output stall, flush, id_valid, id_rs_data, id_rt_data, id_imm,
           id_rs_addr, id_rt_addr, id_rd_addr, id_uses_rt, id_alu_src,
           id_alu_op, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
    input  ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rs_addr, ex_rt_addr,
           ex_rd_addr, ex_alu_src, ex_alu_op, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_mem_to_reg, id_hold
  );

  modport slave (
    input  stall, flush, id_valid, id_rs_data, id_rt_data, id_imm,
           id_rs_addr, id_rt_addr, id_rd_addr, id_uses_rt, id_alu_src,
           id_alu_op, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
    output ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rs_addr, ex_rt_addr,
           ex_rd_addr, ex_alu_src, ex_alu_op, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_mem_to_reg, id_hold
  );

endinterface

// File: rtl/id_ex_reg_load_use_detect.sv
// Load-use hazard compare: a valid load in EX whose nonzero destination is a
// source of the valid instruction in ID. Purely combinational.
// Inputs : ex_valid, ex_mem_read, ex_rd_addr, id_valid, id_rs_addr, id_rt_addr, id_uses_rt
// Output : hazard_c
module load_use_detect
  import pipe_pkg::*;
(
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic                  id_uses_rt,
  output logic                  hazard_c
);

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign hazard_c = ex_valid & ex_mem_read & id_valid &
                    (ex_rd_addr != REG_ADDR_W'(0)) &
                    ((ex_rd_addr == id_rs_addr) |
                     (id_uses_rt & (ex_rd_addr == id_rt_addr)));

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion and stall/flush.
// Priority per edge: flush (bubble) > stall (hold) > load-use (bubble) > load.
// Ports: clk, rst_n (async active-low), bus (id_ex_reg_if.slave),
//        bubble_count [15:0] only when ID_EX_PERF_CNT_EN is defined.
// The immediate is stored raw; sign extension happens in the EX operand mux.
module id_ex_reg
  import pipe_pkg::*;
#(
  parameter int unsigned data_width = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  id_ex_reg_if.slave        bus
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] bubble_count
`endif
);

  typedef struct packed {
    logic                  valid;
    logic [data_width-1:0] rs_data;
    logic [data_width-1:0] rt_data;
    logic [IMM_W-1:0]      imm;
    logic [REG_ADDR_W-1:0] rs_addr;
    logic [REG_ADDR_W-1:0] rt_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    ex_ctrl_t              ctrl;
  } slot_t;

  slot_t slot_q;
  slot_t slot_d;
  slot_t id_slot;
  logic  hazard_c;

  // Decode-stage fields gathered into one slot.
  always_comb begin
    id_slot.valid           = bus.id_valid;
    id_slot.rs_data         = bus.id_rs_data;
    id_slot.rt_data         = bus.id_rt_data;
    id_slot.imm             = bus.id_imm;
    id_slot.rs_addr         = bus.id_rs_addr;
    id_slot.rt_addr         = bus.id_rt_addr;
    id_slot.rd_addr         = bus.id_rd_addr;
    id_slot.ctrl.alu_src    = bus.id_alu_src;
    id_slot.ctrl.alu_op     = bus.id_alu_op;
    id_slot.ctrl.reg_write  = bus.id_reg_write;
    id_slot.ctrl.mem_read   = bus.id_mem_read;
    id_slot.ctrl.mem_write  = bus.id_mem_write;
    id_slot.ctrl.mem_to_reg = bus.id_mem_to_reg;
  end

  load_use_detect u_load_use_detect (
    .ex_valid    (slot_q.valid),
    .ex_mem_read (slot_q.ctrl.mem_read),
    .ex_rd_addr  (slot_q.rd_addr),
    .id_valid    (bus.id_valid),
    .id_rs_addr  (bus.id_rs_addr),
    .id_rt_addr  (bus.id_rt_addr),
    .id_uses_rt  (bus.id_uses_rt),
    .hazard_c    (hazard_c)
  );

  // Next EX slot selection; a bubble is all-zero including control.
  always_comb begin
    slot_d = slot_q;
    if (bus.flush) begin
      slot_d = '0;
    end else if (bus.stall) begin
      slot_d = slot_q;
    end else if (hazard_c) begin
      slot_d = '0;
    end else begin
      slot_d = id_slot;
    end
  end

  // EX slot register; reset leaves a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign bus.id_hold = bus.stall | (hazard_c & ~bus.flush);

  assign bus.ex_valid      = slot_q.valid;
  assign bus.ex_rs_data    = slot_q.rs_data;
  assign bus.ex_rt_data    = slot_q.rt_data;
  assign bus.ex_imm        = slot_q.imm;
  assign bus.ex_rs_addr    = slot_q.rs_addr;
  assign bus.ex_rt_addr    = slot_q.rt_addr;
  assign bus.ex_rd_addr    = slot_q.rd_addr;
  assign bus.ex_alu_src    = slot_q.ctrl.alu_src;
  assign bus.ex_alu_op     = slot_q.ctrl.alu_op;
  assign bus.ex_reg_write  = slot_q.ctrl.reg_write;
  assign bus.ex_mem_read   = slot_q.ctrl.mem_read;
  assign bus.ex_mem_write  = slot_q.ctrl.mem_write;
  assign bus.ex_mem_to_reg = slot_q.ctrl.mem_to_reg;

`ifdef ID_EX_PERF_CNT_EN
  logic                  bubble_evt_c;
  logic [PERF_CNT_W-1:0] bubble_cnt_q;

  // Counts flush bubbles and hazard bubbles (hazard only loads when not stalled).
  assign bubble_evt_c = bus.flush | (~bus.stall & hazard_c);

  // Saturating bubble counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
    end else if (bubble_evt_c && (bubble_cnt_q != {PERF_CNT_W{1'b1}})) begin
      bubble_cnt_q <= bubble_cnt_q + PERF_CNT_W'(1);
    end
  end

  assign bubble_count = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed table-driven bench for id_ex_reg plus reset and counter sequences.
module tb_id_ex_reg;
  import pipe_pkg::*;

  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {E_LOAD, E_BUB, E_KEEP} exp_mode_t;

  typedef struct packed {
    logic                  valid;
    logic [DW-1:0]         rs_data;
    logic [DW-1:0]         rt_data;
    logic [IMM_W-1:0]      imm;
    logic [REG_ADDR_W-1:0] rs_addr;
    logic [REG_ADDR_W-1:0] rt_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    ex_ctrl_t              ctrl;
  } ex_t;

  typedef struct {
    logic      stall;
    logic      flush;
    logic      uses_rt;
    ex_t       id;
    logic      exp_hold;
    exp_mode_t mode;
  } vec_t;

  localparam ex_ctrl_t C_LW   = '{alu_src: 1'b1, alu_op: 4'h2, reg_write: 1'b1,
                                  mem_read: 1'b1, mem_write: 1'b0, mem_to_reg: 1'b1};
  localparam ex_ctrl_t C_ADD  = '{alu_src: 1'b0, alu_op: 4'h1, reg_write: 1'b1,
                                  mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0};
  localparam ex_ctrl_t C_ADDI = '{alu_src: 1'b1, alu_op: 4'h1, reg_write: 1'b1,
                                  mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  id_ex_reg_if #(.data_width(DW)) bus ();

`ifdef ID_EX_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] bubble_count;
`endif

  id_ex_reg #(.data_width(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .bubble_count (bubble_count)
`endif
  );

  ex_t act;
  assign act.valid           = bus.ex_valid;
  assign act.rs_data         = bus.ex_rs_data;
  assign act.rt_data         = bus.ex_rt_data;
  assign act.imm             = bus.ex_imm;
  assign act.rs_addr         = bus.ex_rs_addr;
  assign act.rt_addr         = bus.ex_rt_addr;
  assign act.rd_addr         = bus.ex_rd_addr;
  assign act.ctrl.alu_src    = bus.ex_alu_src;
  assign act.ctrl.alu_op     = bus.ex_alu_op;
  assign act.ctrl.reg_write  = bus.ex_reg_write;
  assign act.ctrl.mem_read   = bus.ex_mem_read;
  assign act.ctrl.mem_write  = bus.ex_mem_write;
  assign act.ctrl.mem_to_reg = bus.ex_mem_to_reg;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, a, e);
    end
  endtask

  task automatic chk_ex(input string tag, input ex_t e);
    chk({tag, ".valid"}, 32'(act.valid), 32'(e.valid));
    chk({tag, ".rs_data"}, act.rs_data, e.rs_data);
    chk({tag, ".rt_data"}, act.rt_data, e.rt_data);
    chk({tag, ".imm"}, 32'(act.imm), 32'(e.imm));
    chk({tag, ".addrs"}, 32'({act.rs_addr, act.rt_addr, act.rd_addr}),
        32'({e.rs_addr, e.rt_addr, e.rd_addr}));
    chk({tag, ".ctrl"}, 32'(act.ctrl), 32'(e.ctrl));
  endtask

  task automatic drive(input logic st, input logic fl, input logic ut, input ex_t s);
    bus.stall         = st;
    bus.flush         = fl;
    bus.id_uses_rt    = ut;
    bus.id_valid      = s.valid;
    bus.id_rs_data    = s.rs_data;
    bus.id_rt_data    = s.rt_data;
    bus.id_imm        = s.imm;
    bus.id_rs_addr    = s.rs_addr;
    bus.id_rt_addr    = s.rt_addr;
    bus.id_rd_addr    = s.rd_addr;
    bus.id_alu_src    = s.ctrl.alu_src;
    bus.id_alu_op     = s.ctrl.alu_op;
    bus.id_reg_write  = s.ctrl.reg_write;
    bus.id_mem_read   = s.ctrl.mem_read;
    bus.id_mem_write  = s.ctrl.mem_write;
    bus.id_mem_to_reg = s.ctrl.mem_to_reg;
  endtask

  function automatic vec_t mk(input logic st, input logic fl, input logic v,
                              input logic [31:0] rsd, input logic [31:0] rtd,
                              input logic [15:0] imm, input int rs, input int rt,
                              input int rd, input logic ut, input ex_ctrl_t c,
                              input logic hold, input exp_mode_t m);
    vec_t r;
    r.stall      = st;
    r.flush      = fl;
    r.uses_rt    = ut;
    r.id.valid   = v;
    r.id.rs_data = rsd;
    r.id.rt_data = rtd;
    r.id.imm     = imm;
    r.id.rs_addr = REG_ADDR_W'(rs);
    r.id.rt_addr = REG_ADDR_W'(rt);
    r.id.rd_addr = REG_ADDR_W'(rd);
    r.id.ctrl    = c;
    r.exp_hold   = hold;
    r.mode       = m;
    return r;
  endfunction

  vec_t vecs [23];
  ex_t  exp_ex;
  ex_t  zero_ex;

  initial begin
    zero_ex = '0;
    drive(1'b0, 1'b0, 1'b0, zero_ex);

    // Reset state.
    #3;
    chk_ex("reset", zero_ex);
    chk("reset.id_hold", 32'(bus.id_hold), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Load a lw rd=5, then present a dependent instruction and reset mid-cycle.
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, mk(0,0,1,32'hA,0,16'h4,2,0,5,0,C_LW,0,E_LOAD).id);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, mk(0,0,1,32'h11,32'h22,0,5,6,8,1,C_ADD,0,E_LOAD).id);
    #1;
    chk("pre_reset.id_hold", 32'(bus.id_hold), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_ex("async_reset", zero_ex);
    chk("async_reset.id_hold", 32'(bus.id_hold), 32'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_ex("post_reset", '{valid: 1'b1, rs_data: 32'h11, rt_data: 32'h22, imm: 16'h0,
                           rs_addr: 5'd5, rt_addr: 5'd6, rd_addr: 5'd8, ctrl: C_ADD});
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    vecs[0]  = mk(0,0,1,32'h1234,32'h5678,16'h8001,1,2,3,0,C_ADDI,0,E_LOAD);
    vecs[1]  = mk(0,0,1,32'hA,0,16'h0004,2,0,5,0,C_LW,0,E_LOAD);
    vecs[2]  = mk(0,0,1,32'h11,32'h22,0,5,6,8,1,C_ADD,1,E_BUB);
    vecs[3]  = mk(0,0,1,32'h11,32'h22,0,5,6,8,1,C_ADD,0,E_LOAD);
    vecs[4]  = mk(0,0,1,32'h33,0,16'h0010,1,0,0,0,C_LW,0,E_LOAD);
    vecs[5]  = mk(0,0,1,32'h44,32'h55,0,0,4,9,1,C_ADD,0,E_LOAD);
    vecs[6]  = mk(0,0,1,32'h66,0,16'h0008,3,0,7,0,C_LW,0,E_LOAD);
    vecs[7]  = mk(0,0,1,32'h67,32'h68,16'hFFFF,1,7,0,0,C_ADDI,0,E_LOAD);
    vecs[8]  = mk(0,0,1,32'h66,0,16'h0008,3,0,7,0,C_LW,0,E_LOAD);
    vecs[9]  = mk(0,0,1,32'h69,32'h6A,0,1,7,10,1,C_ADD,1,E_BUB);
    vecs[10] = mk(0,0,1,32'h69,32'h6A,0,1,7,10,1,C_ADD,0,E_LOAD);
    vecs[11] = mk(0,0,0,32'h77,32'h78,16'h1234,2,3,4,0,C_LW,0,E_LOAD);
    vecs[12] = mk(0,0,1,32'h79,32'h7A,0,4,4,11,1,C_ADD,0,E_LOAD);
    vecs[13] = mk(0,0,1,32'h80,0,16'h0020,1,0,12,0,C_LW,0,E_LOAD);
    vecs[14] = mk(1,1,1,32'h81,32'h82,0,12,2,13,1,C_ADD,1,E_BUB);
    vecs[15] = mk(0,0,1,32'h80,0,16'h0020,1,0,12,0,C_LW,0,E_LOAD);
    vecs[16] = mk(0,1,1,32'h81,32'h82,0,12,2,13,1,C_ADD,0,E_BUB);
    vecs[17] = mk(0,0,1,32'h80,0,16'h0020,1,0,12,0,C_LW,0,E_LOAD);
    vecs[18] = mk(1,0,1,32'h81,32'h82,0,12,2,13,1,C_ADD,1,E_KEEP);
    vecs[19] = mk(1,0,1,32'h90,32'h91,16'h7FFF,3,4,14,1,C_ADDI,1,E_KEEP);
    vecs[20] = mk(1,0,1,32'h81,32'h82,0,12,2,13,1,C_ADD,1,E_KEEP);
    vecs[21] = mk(0,0,1,32'h81,32'h82,0,12,2,13,1,C_ADD,1,E_BUB);
    vecs[22] = mk(0,0,1,32'h81,32'h82,0,12,2,13,1,C_ADD,0,E_LOAD);

    exp_ex = '0;
    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].uses_rt, vecs[i].id);
      #1;
      chk($sformatf("v%0d.id_hold", i), 32'(bus.id_hold), 32'(vecs[i].exp_hold));
      case (vecs[i].mode)
        E_LOAD:  exp_ex = vecs[i].id;
        E_BUB:   exp_ex = '0;
        default: exp_ex = exp_ex;
      endcase
      @(posedge clk); #1;
      chk_ex($sformatf("v%0d", i), exp_ex);
    end

`ifdef ID_EX_PERF_CNT_EN
    // Table produced bubbles at v2, v9, v14, v16, v21.
    chk("bubble_count.table", 32'(bubble_count), 32'd5);
    drive(1'b0, 1'b1, 1'b0, zero_ex);
    repeat (65540) @(posedge clk);
    #1;
    chk("bubble_count.sat", 32'(bubble_count), 32'h0000_FFFF);
    bus.flush = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

ID/EX pipeline register for the pipelined datapath.
- Captures decoded operands, the raw 16-bit immediate and control from the decode stage.
- Presents them to the execute stage, where the ALU-source mux selects between `ex_rt_data` and the sign-extended `ex_imm`.
- Owns load-use hazard detection: inserts one bubble and tells decode/fetch to hold.
- Implements external stall (hold) and flush (bubble) with fixed priority.

## Interface
- `data_width`, 32, register operand width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `stall`  in  1  downstream stall; hold all EX outputs
- `flush`  in  1  squash; next EX contents become a bubble
- `id_valid`  in  1  decode slot holds a real instruction
- `id_rs_data`, `id_rt_data`  in  data_width  register file read data
- `id_imm`  in  16  raw immediate field, not extended
- `id_rs_addr`, `id_rt_addr`, `id_rd_addr`  in  5 each  source/destination register numbers
- `id_uses_rt`  in  1  instruction reads rt as a source
- `id_alu_src`  in  1  1 = immediate operand
- `id_alu_op`  in  4  ALU operation code
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`  in  1 each  control strobes
- `ex_*`  out  matching widths  registered copies of every `id_*` above except `id_valid` and `id_uses_rt`
- `ex_valid`  out  1  EX slot holds a real instruction
- `id_hold`  out  1  combinational; decode and fetch must not advance this cycle

## Operation
Update priority at each rising edge, highest first:
- **`flush`**: load a bubble. Wins over `stall` and hazard.
- **`stall`**: hold every EX register unchanged. `id_hold` = 1.
- **Load-use hazard**: load a bubble. `id_hold` = 1.
  - Hazard condition: `ex_valid & ex_mem_read & id_valid & (ex_rd_addr != 0) & ((ex_rd_addr == id_rs_addr) | (id_uses_rt & (ex_rd_addr == id_rt_addr)))`.
- **Otherwise**: load all `id_*` fields. `ex_valid` = `id_valid`.

Bubble contents:
- `ex_valid` and all control strobes = 0.
- Data, address, `alu_op` and `alu_src` fields = 0. A bubble is bit-exact zero.

Other rules:
- Invalid decode slot (`id_valid` = 0) is loaded as-is. It never raises a hazard.
- `id_hold` = `stall | (hazard & ~flush)`. It is purely combinational from current EX state and ID inputs.
- The immediate is stored unextended. Sign extension belongs to the execute-stage mux.

## Timing
- Latency: 1 cycle from the ID input to the EX output.
- Reset (async assert, sync-safe deassert via `rst_n`): all outputs 0, i.e. EX holds a bubble.
- Reset mid-stall or mid-hazard: state clears immediately. The hazard cannot re-fire because `ex_valid` = 0.
- Load-use costs exactly one bubble cycle. The bubble clears `ex_mem_read`, so the held instruction loads on the next edge.
- `stall` and hazard together: hold (stall), with no bubble. The hazard is re-evaluated once `stall` drops.
- `flush` and `stall` together: bubble is loaded, and `id_hold` = 1 still (because of `stall`).

## Configuration
- `ID_EX_PERF_CNT_EN`
  - **Defined:** adds output `bubble_count` [15:0].
    - Increments on each edge where a hazard bubble or a flush bubble is loaded.
    - Saturates at 0xFFFF.
    - Resets to 0.
  - **Undefined:** no port, no counter logic. All other behaviour is identical.

## Structure
- Shared package `pipe_pkg`:
  - `REG_ADDR_W` = 5, `IMM_W` = 16, `ALU_OP_W` = 4.
  - Packed struct `ex_ctrl_t` (`alu_src`, `alu_op`, `reg_write`, `mem_read`, `mem_write`, `mem_to_reg`).
  - Constant `EX_CTRL_BUBBLE` (all zero).
- Sub-module `load_use_detect`: pure combinational hazard compare. It is reused later by the forwarding unit.

## Test plan
- **Reset:** `rst_n` low mid-cycle with EX loaded → all `ex_*` = 0 asynchronously; `id_hold` = 0.
- **Plain load:** `id_rs_data` = 0x0000_1234, `id_imm` = 0x8001, `id_alu_src` = 1, `id_valid` = 1 → next cycle `ex_imm` = 0x8001, `ex_rs_data` = 0x1234, `ex_valid` = 1.
- **Load-use:** EX holds lw with `rd` = 5. ID has `rs` = 5 → `id_hold` = 1 and the next EX is a bubble. The cycle after, the ID instruction appears. Repeat with `rd` = 0 → no hazard.
- **rt hazard gating:** EX lw `rd` = 7, ID `rt` = 7, `id_uses_rt` = 0 → no hazard. With `id_uses_rt` = 1 → hazard.
- **Priority:** `flush` and `stall` both high with a hazard present → bubble loaded, `id_hold` = 1. `stall` alone for 3 cycles → EX unchanged for all 3.
- **Perf counter (`ID_EX_PERF_CNT_EN`):** 2 hazards + 1 flush → `bubble_count` = 3. Preload near max → holds at 0xFFFF.
